// File: rtl/uart_tx_arb_if.sv
// Requester-side and TX-FIFO-side signals of the UART transmit arbiter.
// No latency of its own; just wires grouped for connection.
// Backpressure is carried by req_ready (towards requesters) and tf_full (from the FIFO).
interface uart_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [9*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        lock_max;
  logic              tf_write;
  logic [8:0]        tf_wbyte;
  logic              tf_full;
  logic [NREQ-1:0]   grant;
  logic              busy;

  // Side that owns the requesters and the FIFO (the arbiter's environment).
  modport master (
    output req_en, req_valid, req_last, req_data, lock_max, tf_full,
    input  req_ready, tf_write, tf_wbyte, grant, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_en, req_valid, req_last, req_data, lock_max, tf_full,
    output req_ready, tf_write, tf_wbyte, grant, busy
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting one of NREQ byte streams exclusive access to a UART TX FIFO.
// Grant appears one clock after a candidate is seen in IDLE; accepted bytes pass through combinationally.
// tf_full stalls the owner (ready low, no write) without releasing; owner keeps the grant until a release condition.
module uart_tx_arb #(
  parameter int NREQ     = 4,
  parameter int IDLE_TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_n,
  uart_tx_arb_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last_owner;
  logic [7:0]      r_burst;
  logic [3:0]      r_idle;

  logic [NREQ-1:0] w_cand;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;
  logic [NREQ-1:0] w_ready;
  logic            w_accept;
  logic            w_own_vld;
  logic            w_own_en;
  logic            w_own_last;
  logic [7:0]      w_burst_inc;
  logic [3:0]      w_idle_inc;
  logic            w_rel;

  // Index k steps after base, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s -= NREQ;
    return IW'(s);
  endfunction

  assign w_cand = bus.req_valid & bus.req_en;

  // Round-robin search from the requester after the last owner; ineligible ones cost no cycles.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = rr_idx(r_last_owner, k);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_own_vld  = bus.req_valid[r_owner];
  assign w_own_en   = bus.req_en[r_owner];
  assign w_own_last = bus.req_last[r_owner];

  assign w_ready        = (r_state == S_XFER && !bus.tf_full) ? r_grant : '0;
  assign w_accept       = |(bus.req_valid & w_ready);
  assign bus.req_ready  = w_ready;
  assign bus.tf_write   = w_accept;
  assign bus.tf_wbyte   = bus.req_data[9*r_owner +: 9];
  assign bus.grant      = r_grant;
  assign bus.busy       = r_busy;

  // Burst count saturates so an unlimited grant cannot wrap back to a small value.
  assign w_burst_inc = (r_burst == 8'hFF) ? r_burst : r_burst + 8'd1;
  // Never wraps: release fires as soon as it reaches IDLE_TMO (at most 15).
  assign w_idle_inc  = r_idle + 4'd1;

  assign w_rel = (w_accept && w_own_last)
              || (w_accept && bus.lock_max != 8'd0 && w_burst_inc == bus.lock_max)
              || !w_own_en
              || (!w_own_vld && w_idle_inc == 4'(IDLE_TMO));

  // Arbitration FSM: grab an owner in IDLE, stream its bytes in XFER until a release condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= IW'(NREQ - 1);
      r_burst      <= '0;
      r_idle       <= '0;
    end else if (!clr_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= IW'(NREQ - 1);
      r_burst      <= '0;
      r_idle       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_XFER;
            r_grant <= NREQ'(1) << w_pick;
            r_busy  <= 1'b1;
            r_owner <= w_pick;
            r_burst <= '0;
            r_idle  <= '0;
          end
        end
        S_XFER: begin
          if (w_accept) r_burst <= w_burst_inc;
          // A valid byte held off by tf_full still counts as activity, not idleness.
          if (w_own_vld) r_idle <= '0;
          else           r_idle <= w_idle_inc;
          // Release always passes through IDLE, so the same owner cannot be regranted back-to-back.
          if (w_rel) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter IDLE_TMO, default 15, SHALL set the cycles an owner may hold the grant with req_valid low before forced release (1..15).
REQ-003 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 clr_n  in  1  synchronous clear, active low; same effect as reset.
REQ-006 req_en  in  NREQ  per-requester enable.
REQ-007 req_valid  in  NREQ  requester i has a byte.
REQ-008 req_last  in  NREQ  byte from requester i ends its packet.
REQ-009 req_data  in  9*NREQ  byte i at bits [9i+8:9i]; 9 bits to cover 9-bit UART frames.
REQ-010 req_ready  out  NREQ  byte i accepted this cycle when valid&ready.
REQ-011 lock_max  in  8  max bytes per grant; 0 = unlimited.
REQ-012 tf_write  out  1  TX FIFO write strobe.
REQ-013 tf_wbyte  out  9  TX FIFO write data.
REQ-014 tf_full  in  1  TX FIFO full.
REQ-015 grant  out  NREQ  one-hot current owner, registered; all-zero when none.
REQ-016 busy  out  1  high when state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE and XFER only.
REQ-018 IDLE: if (req_valid & req_en) is nonzero, the next clock SHALL load grant with one candidate, chosen round-robin starting at last_owner+1 mod NREQ; burst count and idle count SHALL clear; state SHALL go to XFER.
REQ-019 IDLE with no candidate: state, grant and last_owner SHALL hold.
REQ-020 req_ready[i] SHALL be combinational = grant[i] & ~tf_full & state==XFER; all other bits SHALL be 0.
REQ-021 tf_write SHALL be combinational = |(req_valid & req_ready).
REQ-022 tf_wbyte SHALL be the req_data slice of the owner; it is don't-care when tf_write is 0.
REQ-023 Each accepted byte SHALL increment the 8-bit burst count.
REQ-024 XFER SHALL release, meaning grant<=0, last_owner<=owner index and state<=IDLE on the next clock, when any of the following holds:
  (a) accepted byte has req_last set;
  (b) lock_max!=0 and the accepted byte makes burst count equal lock_max;
  (c) owner req_en is low;
  (d) idle count reaches IDLE_TMO.
REQ-025 Idle count SHALL increment on each XFER cycle with owner req_valid low and clear on any cycle with it high; cycles where tf_full blocks a valid byte SHALL NOT count.
REQ-026 After a release, at least one IDLE cycle SHALL separate grants, so the same requester never holds the grant on consecutive cycles.
REQ-027 Requesters that are disabled or not valid SHALL be skipped in the round-robin search with no extra cycles.
REQ-028 Disabling a non-owner mid-packet SHALL NOT affect the current owner.
REQ-029 tf_full high for any duration SHALL stall the owner without release or loss; no byte SHALL be written while tf_full=1.
REQ-030 Burst count SHALL saturate at 255 when lock_max=0.

Reset
REQ-031 On rst or ~clr_n: state=IDLE, grant=0, busy=0, last_owner=NREQ-1 (requester 0 first), counters=0; req_ready and tf_write therefore 0.
REQ-032 Reset mid-packet SHALL abort the grant immediately; the partial packet is not completed.

Verification
REQ-033 Reset release with req_valid=4'b0101 and all enabled -> grant=0001 one cycle later; after req0 last, one IDLE cycle, then grant=0100.
REQ-034 All four requesters streaming 3-byte packets with lock_max=0 -> grants in order 0,1,2,3,0; tf_wbyte sequence matches each packet contiguously.
REQ-035 lock_max=2 and req1 sends a 5-byte packet -> release after 2 bytes, other requesters served, then req1 resumes with byte 3.
REQ-036 tf_full held high 20 cycles mid-packet -> tf_write=0 throughout, no release, all bytes delivered once after full drops.
REQ-037 Owner drops req_valid for 15 cycles (IDLE_TMO=15) -> grant=0 on the following clock; owner drops req_en -> release in one cycle.
REQ-038 clr_n pulsed low mid-packet -> grant=0 and busy=0 next cycle; arbitration restarts from requester 0.
